out_port_uart_tx: RTL and testbench
===================================

Name: out_port_uart_tx

Overview:
- Serial back end for the memory-mapped parallel output port.
- Accepts the same qualified write strobe and data byte that load the port register, and buffers them in a small FIFO.
- Transmits each byte as an 8N1 UART frame on a single tx pin, giving the single-cycle RV32I core a byte-stream debug/console output.
- Sits directly downstream of the output-port decode; software stores to the port address, and this block serializes them.

Parameters:
WIDTH, 8, data bits per frame and write-data width
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
FIFO_DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
EN  input  1  write strobe, already qualified with port address match; one push per high cycle
DataIn  input  WIDTH  byte to enqueue (RegData path)
tx  output  1  serial line, idle high, registered
busy  output  1  high while FIFO non-empty or frame in progress
full  output  1  FIFO holds FIFO_DEPTH entries
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky; set when a write is dropped

Behaviour:
- Reset (rst=0, asynchronous, any state, mid-frame included):
  - tx=1, busy=0, full=0, count=0, overflow=0.
  - FIFO pointers zeroed, FSM=IDLE, baud and bit counters 0, shift register 0.
  - Effective immediately, without waiting for a clock edge.
- Push: at rising edge with EN=1 and full=0, DataIn is written at the write pointer; wptr increments modulo FIFO_DEPTH.
- Push with full=1: data dropped, overflow<=1. overflow is cleared only by reset.
- full is evaluated on registered count. A push while full is rejected even if a pop occurs in the same cycle.
- Simultaneous push and pop: both occur, count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count!=0 at a rising edge: pop head into shift register, rptr++, baud counter cleared, state<=START. A byte pushed at edge k is popped at edge k+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit WIDTH-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame timing: exactly (WIDTH+2)*CLKS_PER_BIT cycles from START entry to IDLE re-entry. Back-to-back frames are separated by exactly one IDLE cycle (tx=1).
- tx is a registered FSM output. It changes only on clock edges, except at reset.
- busy = (state!=IDLE) | (count!=0), combinational from registers.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Bit index counts 0..WIDTH-1. count is never negative and never exceeds FIFO_DEPTH.
- EN while rst=0 has no effect.

Test Plan:
- Use CLKS_PER_BIT=4, WIDTH=8, FIFO_DEPTH=4 in the bench.
1. Reset: rst=0 for 2 cycles, EN=0 -> tx=1, busy=0, full=0, count=0, overflow=0; after rst=1, tx stays 1 for 20 idle cycles.
2. Single write 0xA5 at edge k:
   - count=1 after k; tx falls after edge k+1.
   - tx sequence in 4-cycle bits: 0 | 1,0,1,0,0,1,0,1 | 1.
   - busy falls after edge k+41; count returns to 0.
3. Six consecutive EN cycles with 0x11..0x66:
   - 0x11 popped at the second edge.
   - Writes 2-5 fill the FIFO, full=1 after the fifth edge.
   - 0x66 dropped, overflow=1.
   - Frames 0x11..0x55 emitted in order, each separated by exactly one idle tx=1 cycle.
4. Reset mid-frame: write 0xFF, then drive rst=0 during DATA bit 3 -> tx=1 immediately (asynchronous), count=0, busy=0; after release, no residual frame.
5. Simultaneous push/pop: FIFO count=2 in IDLE, EN=1 at the pop edge -> count stays 2, ordering preserved on tx.
6. Overflow stickiness: after overflow=1, drain the FIFO and write normally -> overflow stays 1 until rst pulse.

Source files
------------

// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx
//   Serial back end for the memory-mapped output port. Every accepted port
//   write is queued in a small FIFO and then sent on tx as an 8N1 frame:
//   one low start bit, WIDTH data bits LSB first, one high stop bit.
//   Each bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk      : system clock; all state changes on the rising edge
//   rst      : asynchronous, active-low reset
//   EN       : qualified port write strobe; one push per high cycle
//   DataIn   : byte to enqueue
//   tx       : registered serial output, high when idle
//   busy     : FIFO not empty, or a frame is in progress
//   full     : FIFO holds FIFO_DEPTH entries
//   count    : current FIFO occupancy
//   overflow : sticky flag, set when a write arrives while the FIFO is full
module out_port_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          EN,
  input  logic [WIDTH-1:0]              DataIn,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [BAUD_W-1:0]  r_baud, w_baud_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [WIDTH-1:0]   r_shift, w_shift_nxt;
  logic               r_tx, w_tx_nxt;
  logic               r_overflow;
  logic               w_full, w_push, w_pop, w_baud_end;

  // full comes from the registered count, so a push that lands while full is
  // rejected even if the transmitter frees a slot on the same edge.
  assign w_full     = (r_count == CNT_FULL);
  assign w_push     = EN & ~w_full;
  assign w_baud_end = (r_baud == BAUD_LAST);

  // FIFO storage carries no reset; only pointers and occupancy matter.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= DataIn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (EN && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // tx is registered from the state being entered, so the line level lines up
  // exactly with the state boundaries instead of lagging one cycle behind.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE) | (r_count != '0);
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_out_port_uart_tx.sv
module tb_out_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       EN = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       tx, busy, full, overflow;
  logic [2:0] count;

  out_port_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .EN(EN), .DataIn(DataIn), .tx(tx),
    .busy(busy), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Reference model: a queue of accepted bytes, and a transmitter that can
  // take a byte whenever the previous frame plus one idle cycle has elapsed.
  typedef struct { logic [7:0] d; int t; } frame_t;

  int         cyc = 0;
  logic [7:0] mq[$];
  frame_t     exp_q[$];
  int         next_pop = 0;
  int         last_pop = -1000;
  bit         m_ovf = 1'b0;
  int         m_t;
  bit         m_full, m_popnow;
  frame_t     m_f;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      exp_q.delete();
      next_pop = 0;
      last_pop = -1000;
      m_ovf    = 1'b0;
    end else begin
      m_t      = cyc + 1;
      m_full   = (mq.size() == DEPTH);
      m_popnow = (mq.size() != 0) && (m_t >= next_pop);
      if (m_popnow) begin
        m_f.d = mq.pop_front();
        m_f.t = m_t;
        exp_q.push_back(m_f);
        last_pop = m_t;
        next_pop = m_t + FRAME + 1;
      end
      if (EN) begin
        if (!m_full) mq.push_back(DataIn);
        else m_ovf = 1'b1;
      end
    end
  end

  // Monitor: per-cycle status against the model, and a UART receiver that
  // captures each frame and pops the scoreboard when the frame completes.
  logic sbuf[FRAME];
  int   mon_n = 0;
  bit   in_frame = 1'b0;
  int   fr_start;

  task automatic finish_frame();
    logic [7:0] d;
    bit         shape;
    frame_t     f;
    shape = (sbuf[0] == 1'b0) && (sbuf[FRAME-CPB] == 1'b1);
    for (int b = 0; b < 10; b++)
      for (int s = 0; s < CPB; s++)
        if (sbuf[b*CPB+s] !== sbuf[b*CPB]) shape = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = sbuf[(i+1)*CPB];
    chk("frame_shape", {31'd0, shape}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_unexpected: got byte %0h expected no frame", d);
    end else begin
      f = exp_q.pop_front();
      chk("frame_data", {24'd0, d}, {24'd0, f.d});
      chk("frame_start_cycle", fr_start, f.t);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 1'b0;
      mon_n    = 0;
    end else begin
      chk("count", {29'd0, count}, mq.size());
      chk("full", {31'd0, full}, {31'd0, (mq.size() == DEPTH)});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      chk("busy", {31'd0, busy},
          {31'd0, (mq.size() != 0) || (cyc >= last_pop && cyc < last_pop + FRAME)});
      if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          fr_start = cyc;
          sbuf[0]  = tx;
          mon_n    = 1;
        end
      end else begin
        sbuf[mon_n] = tx;
        mon_n++;
        if (mon_n == FRAME) begin
          finish_frame();
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      EN = 1'b0;
    end
  endtask

  task automatic wr(logic [7:0] b);
    @(negedge clk);
    EN     = 1'b1;
    DataIn = b;
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    idle(1);
    while ((mq.size() != 0 || exp_q.size() != 0 || cyc < last_pop + FRAME + 1) && budget > 0) begin
      idle(1);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, tx}, 32'd1);
    chk("rst_async_count", {29'd0, count}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_full", {31'd0, full}, 32'd0);
    chk("rst_async_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_tx_high(int n);
    repeat (n) begin
      @(negedge clk);
      EN = 1'b0;
      #1 chk("idle_tx", {31'd0, tx}, 32'd1);
    end
  endtask

  initial begin
    int budget;
    int rate;
    // Reset state while held
    repeat (2) @(negedge clk);
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_tx_high(20);

    // Single frame
    wr(8'hA5);
    drain();

    // Burst of six: fills FIFO, last write dropped
    for (int i = 1; i <= 6; i++) wr(8'(i * 8'h11));
    idle(1);
    #1 chk("burst_overflow", {31'd0, overflow}, 32'd1);
    drain();

    // Overflow stays set across normal traffic
    wr(8'h42);
    drain();
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);
    rst_pulse();
    idle_tx_high(5);

    // Reset during DATA bit 3, once with a high bit and once with a low bit
    wr(8'hFF);
    idle(18);
    rst_pulse();
    idle_tx_high(50);
    wr(8'h00);
    idle(18);
    #1 chk("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    rst_pulse();
    idle_tx_high(50);

    // Simultaneous push and pop with two entries waiting
    wr(8'h3C);
    idle(3);
    wr(8'hC3);
    wr(8'h5A);
    idle(1);
    budget = 100;
    while (cyc + 1 != next_pop && budget > 0) begin
      idle(1);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("FAIL pushpop_timeout: got cycle %0d expected pop edge %0d", cyc, next_pop);
    end
    wr(8'h77);
    idle(1);
    #1 chk("pushpop_count", {29'd0, count}, 32'd2);
    drain();

    // Randomized traffic at varying write rates
    for (int seg = 0; seg < 15; seg++) begin
      rate = $urandom_range(1, 40);
      repeat (200) begin
        @(negedge clk);
        EN     = ($urandom_range(0, rate - 1) == 0);
        DataIn = 8'($urandom);
      end
    end
    drain();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
